// File: rtl/voice_sequencer_if.sv
// rtl/voice_sequencer_if.sv - note table write bus between host registers and the step sequencer
interface voice_sequencer_if #(
    parameter int FREQ_BITS      = 16,
    parameter int STEP_ADDR_BITS = 4,
    parameter int DUR_BITS       = 8
);
    logic                      wr_en;
    logic [STEP_ADDR_BITS-1:0] wr_addr;
    logic [FREQ_BITS-1:0]      wr_freq;
    logic [DUR_BITS-1:0]       wr_dur;
    logic [1:0]                wr_wave;

    modport master (output wr_en, wr_addr, wr_freq, wr_dur, wr_wave);
    modport slave  (input  wr_en, wr_addr, wr_freq, wr_dur, wr_wave);
endinterface

// File: rtl/voice_sequencer.sv
// rtl/voice_sequencer.sv - programmable note-table step sequencer driving one wave voice
module voice_sequencer #(
    parameter int FREQ_BITS      = 16,
    parameter int STEP_ADDR_BITS = 4,
    parameter int DUR_BITS       = 8,
    parameter int TICK_DIV       = 1000
) (
    input  logic                      main_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [STEP_ADDR_BITS-1:0] last_step,
    voice_sequencer_if.slave          wr,
    output logic [FREQ_BITS-1:0]      tone_freq,
    output logic                      en_noise,
    output logic                      en_triangle,
    output logic                      test,
    output logic                      gate,
    output logic [STEP_ADDR_BITS-1:0] step_idx,
    output logic                      running,
    output logic                      done
);
    localparam int DEPTH    = 1 << STEP_ADDR_BITS;
    localparam int PRE_BITS = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_BITS-1:0] PRE_MAX = PRE_BITS'(TICK_DIV - 1);
    localparam logic [DUR_BITS:0]   DUR_ONE = (DUR_BITS+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    state_t state, next_state;

    logic [FREQ_BITS-1:0] tbl_freq [DEPTH];
    logic [DUR_BITS-1:0]  tbl_dur  [DEPTH];
    logic [1:0]           tbl_wave [DEPTH];

    logic [PRE_BITS-1:0] presc;
    logic [DUR_BITS:0]   dur_cnt;

    logic [FREQ_BITS-1:0] cur_freq;
    logic [DUR_BITS-1:0]  cur_dur;
    logic [1:0]           cur_wave;
    logic [DUR_BITS:0]    dur_load;
    logic                 tick, last_tick, at_last, is_rest;

    // Table read is combinational so a same-cycle write is not yet visible to LOAD
    assign cur_freq  = tbl_freq[step_idx];
    assign cur_dur   = tbl_dur[step_idx];
    assign cur_wave  = tbl_wave[step_idx];
    assign is_rest   = (cur_freq == '0);
    assign dur_load  = (cur_dur == '0) ? {1'b1, {DUR_BITS{1'b0}}} : {1'b0, cur_dur};
    assign tick      = (state == PLAY) && (presc == PRE_MAX);
    assign last_tick = tick && (dur_cnt == DUR_ONE);
    assign at_last   = (step_idx == last_step);

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_freq[i] <= '0;
                tbl_dur[i]  <= '0;
                tbl_wave[i] <= '0;
            end
        end else if (wr.wr_en) begin
            tbl_freq[wr.wr_addr] <= wr.wr_freq;
            tbl_dur[wr.wr_addr]  <= wr.wr_dur;
            tbl_wave[wr.wr_addr] <= wr.wr_wave;
        end
    end

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: next_state = PLAY;
            PLAY: if (last_tick) next_state = (!at_last || loop_en) ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
        if (stop) next_state = IDLE;
    end

    always_comb begin
        test    = (state == LOAD);
        running = (state != IDLE);
    end

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            dur_cnt     <= '0;
            step_idx    <= '0;
            tone_freq   <= '0;
            en_noise    <= 1'b0;
            en_triangle <= 1'b0;
            gate        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state == PLAY) && last_tick && at_last && !loop_en && !stop;

            if (state == LOAD) begin
                presc   <= '0;
                dur_cnt <= dur_load;
            end else if (state == PLAY) begin
                presc <= tick ? '0 : presc + PRE_BITS'(1);
                if (tick) dur_cnt <= dur_cnt - DUR_ONE;
            end

            if (next_state == IDLE)
                step_idx <= '0;
            else if (state == PLAY && next_state == LOAD)
                step_idx <= at_last ? '0 : step_idx + STEP_ADDR_BITS'(1);

            // gate drops through each LOAD so the envelope sees a fresh edge per note
            if (next_state == IDLE) begin
                tone_freq   <= '0;
                en_noise    <= 1'b0;
                en_triangle <= 1'b0;
                gate        <= 1'b0;
            end else if (state == LOAD) begin
                tone_freq   <= is_rest ? '0 : cur_freq;
                en_noise    <= !is_rest && cur_wave[0];
                en_triangle <= !is_rest && cur_wave[1];
                gate        <= !is_rest;
            end else if (next_state == LOAD) begin
                gate <= 1'b0;
            end
        end
    end
endmodule
